// File: rtl/ram_bus_master.sv
// ram_bus_master: bus initiator for the shared-bus RAM.
// Takes single-beat write and multi-beat read commands on a valid/ready port.
// It requests the system bus, sequences the RAM address and strobes, drives
// BUS only for a granted write, and returns read beats on a valid/ready
// response port.
// Ports:
//   i_CLOCK, i_RESET_N                  clock, async active-low reset
//   i_CMD_*/o_CMD_READY                 command port (write word / read burst)
//   o_RSP_VALID/i_RSP_READY/o_RSP_DATA  read response port
//   i_BUS_GRANT/o_BUS_REQ               bus arbitration handshake
//   BUS                                 shared tri-state system bus
//   o_MAR_DATA/o_RAM_LOAD/o_RAM_OUT     RAM address and strobes
//   o_BUSY                              high whenever not idle
module ram_bus_master #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RAM_LENGTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = $clog2(RAM_LENGTH),
  parameter int unsigned LEN_WIDTH     = 4
) (
  input  logic                     i_CLOCK,
  input  logic                     i_RESET_N,
  input  logic                     i_CMD_VALID,
  output logic                     o_CMD_READY,
  input  logic                     i_CMD_WRITE,
  input  logic [ADDRESS_WIDTH-1:0] i_CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]    i_CMD_DATA,
  input  logic [LEN_WIDTH-1:0]     i_CMD_LEN,
  output logic                     o_RSP_VALID,
  input  logic                     i_RSP_READY,
  output logic [DATA_WIDTH-1:0]    o_RSP_DATA,
  input  logic                     i_BUS_GRANT,
  output logic                     o_BUS_REQ,
  inout  wire  [DATA_WIDTH-1:0]    BUS,
  output logic [ADDRESS_WIDTH-1:0] o_MAR_DATA,
  output logic                     o_RAM_LOAD,
  output logic                     o_RAM_OUT,
  output logic                     o_BUSY
);

  // Beat counter holds LEN+1, so it needs one bit more than the length field.
  localparam int unsigned BEAT_WIDTH = LEN_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_LENGTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE,
    ST_READ,
    ST_RSP
  } state_e;

  state_e                   state_q, state_d;
  logic                     op_write_q, op_write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [BEAT_WIDTH-1:0]    beats_q, beats_d;
  logic [ADDRESS_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     bus_req_q, bus_req_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     busy_q, busy_d;

  // Strobes and BUS drive follow the grant in the same cycle, so a grant
  // withdrawn mid-access never leaves the bus driven.
  logic drive_bus_c;
  assign drive_bus_c = (state_q == ST_WRITE) && i_BUS_GRANT;

  assign BUS        = drive_bus_c ? data_q : {DATA_WIDTH{1'bz}};
  assign o_RAM_LOAD = drive_bus_c;
  assign o_RAM_OUT  = (state_q == ST_READ) && i_BUS_GRANT;

  assign o_CMD_READY = cmd_ready_q;
  assign o_BUS_REQ   = bus_req_q;
  assign o_RSP_VALID = rsp_valid_q;
  assign o_RSP_DATA  = rsp_data_q;
  assign o_MAR_DATA  = mar_q;
  assign o_BUSY      = busy_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    beats_d    = beats_q;
    mar_d      = mar_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (i_CMD_VALID && cmd_ready_q) begin
          op_write_d = i_CMD_WRITE;
          addr_d     = i_CMD_ADDR;
          data_d     = i_CMD_DATA;
          beats_d    = BEAT_WIDTH'(i_CMD_LEN) + BEAT_WIDTH'(1);
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_BUS_GRANT) begin
          state_d = op_write_q ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        state_d = i_BUS_GRANT ? ST_IDLE : ST_REQ;
      end
      ST_READ: begin
        if (i_BUS_GRANT) begin
          rsp_data_d = BUS;
          state_d    = ST_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        if (i_RSP_READY) begin
          beats_d = beats_q - BEAT_WIDTH'(1);
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDRESS_WIDTH'(1);
          state_d = (beats_q == BEAT_WIDTH'(1)) ? ST_IDLE : ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the state being entered.
    cmd_ready_d = (state_d == ST_IDLE);
    bus_req_d   = (state_d == ST_REQ) || (state_d == ST_WRITE) || (state_d == ST_READ);
    rsp_valid_d = (state_d == ST_RSP);
    busy_d      = (state_d != ST_IDLE);
    if ((state_d == ST_WRITE) || (state_d == ST_READ)) begin
      mar_d = addr_d;
    end
  end

  // State and output registers.
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q     <= ST_IDLE;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      beats_q     <= '0;
      mar_q       <= '0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      bus_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      beats_q     <= beats_d;
      mar_q       <= mar_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      bus_req_q   <= bus_req_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: directed bench for ram_bus_master with a small RAM model
// on the shared bus and a weak probe pattern (8'h5A) placed on BUS whenever
// neither the RAM nor a granted write should be driving it.
module tb_ram_bus_master;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 4;
  localparam logic [DW-1:0] PROBE = 8'h5A;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid, cmd_write, rsp_ready, grant;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [LW-1:0] cmd_len;
  logic          o_CMD_READY, o_RSP_VALID, o_BUS_REQ, o_RAM_LOAD, o_RAM_OUT, o_BUSY;
  logic [DW-1:0] o_RSP_DATA;
  logic [AW-1:0] o_MAR_DATA;
  wire  [DW-1:0] bus;

  logic [DW-1:0] ram_mdl [16];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  logic [DW-1:0] exp_d [16];
  logic [AW-1:0] exp_m [16];
  logic          mon_en;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  ram_bus_master #(.DATA_WIDTH(DW), .RAM_LENGTH(16), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_CLOCK    (clk),
    .i_RESET_N  (rst_n),
    .i_CMD_VALID(cmd_valid),
    .o_CMD_READY(o_CMD_READY),
    .i_CMD_WRITE(cmd_write),
    .i_CMD_ADDR (cmd_addr),
    .i_CMD_DATA (cmd_data),
    .i_CMD_LEN  (cmd_len),
    .o_RSP_VALID(o_RSP_VALID),
    .i_RSP_READY(rsp_ready),
    .o_RSP_DATA (o_RSP_DATA),
    .i_BUS_GRANT(grant),
    .o_BUS_REQ  (o_BUS_REQ),
    .BUS        (bus),
    .o_MAR_DATA (o_MAR_DATA),
    .o_RAM_LOAD (o_RAM_LOAD),
    .o_RAM_OUT  (o_RAM_OUT),
    .o_BUSY     (o_BUSY)
  );

  // RAM drives combinationally on o_RAM_OUT; otherwise the probe pattern sits
  // on the bus unless a write strobe says the master owns it.
  assign bus = o_RAM_OUT ? ram_mdl[o_MAR_DATA] :
               ((!o_RAM_LOAD) ? PROBE : {DW{1'bz}});

  always @(posedge clk) begin
    if (pre_we) ram_mdl[pre_a] <= pre_d;
    else if (o_RAM_LOAD) ram_mdl[o_MAR_DATA] <= bus;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backdoor preload through the RAM model's own write port (one cycle each).
  task automatic ram_put(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Read burst with grant held; each response stalled 'stall' cycles.
  task automatic rd_burst(input logic [AW-1:0] a, input logic [LW-1:0] len, input int stall);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
    cmd_data = 8'hEE; grant = 1'b1;
    #1 chk("rd_ready", o_CMD_READY, 1);
    @(negedge clk); cmd_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      #1 chk("rd_req", {o_BUS_REQ, o_RSP_VALID, o_CMD_READY}, 3'b100);
      @(negedge clk); #1;
      chk("rd_out", {o_RAM_OUT, o_RAM_LOAD}, 2'b10);
      chk("rd_mar", o_MAR_DATA, exp_m[b]);
      @(negedge clk); #1;
      for (int s = 0; s < stall; s++) begin
        chk("rsp_hold", {o_RSP_VALID, o_BUS_REQ, o_RAM_LOAD, o_RAM_OUT}, 4'b1000);
        chk("rsp_hold_d", o_RSP_DATA, exp_d[b]);
        @(negedge clk); #1;
      end
      chk("rsp_valid", {o_RSP_VALID, o_BUS_REQ}, 2'b10);
      chk("rsp_data", o_RSP_DATA, exp_d[b]);
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;
    end
    #1 chk("rd_done", {o_CMD_READY, o_BUSY, o_RSP_VALID}, 3'b100);
  endtask

  // Per-cycle invariants: no strobe overlap, no strobe or bus drive without
  // grant, ready never together with busy.
  always begin
    @(negedge clk); #2;
    if (mon_en) begin
      chk("strobe_overlap", o_RAM_LOAD & o_RAM_OUT, 0);
      chk("ready_busy", o_CMD_READY & o_BUSY, 0);
      if (!grant) chk("strobe_no_grant", {o_RAM_LOAD, o_RAM_OUT}, 0);
      if (!o_RAM_LOAD && !o_RAM_OUT) chk("bus_released", bus, PROBE);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_data = '0; cmd_len = '0;
    rsp_ready = 0; grant = 0; pre_we = 0; pre_a = '0; pre_d = '0; mon_en = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1 chk("rst_ctl", {o_CMD_READY, o_BUSY, o_BUS_REQ, o_RSP_VALID, o_RAM_LOAD, o_RAM_OUT}, 6'b0);
    chk("rst_mar", o_MAR_DATA, 0);
    chk("rst_rdata", o_RSP_DATA, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1 chk("post_rst_ready", {o_CMD_READY, o_BUSY}, 2'b10);

    // 1: write A5 to 3 with grant held, then read it back
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd3; cmd_data = 8'hA5; grant = 1;
    @(negedge clk); cmd_valid = 0;
    #1 chk("wr_req", {o_CMD_READY, o_BUS_REQ, o_RAM_LOAD}, 3'b010);
    @(negedge clk); #1;
    chk("wr_load", {o_RAM_LOAD, o_RAM_OUT}, 2'b10);
    chk("wr_bus", bus, 8'hA5);
    chk("wr_mar", o_MAR_DATA, 3);
    @(negedge clk); #1;
    chk("wr_end", {o_CMD_READY, o_RAM_LOAD, o_BUS_REQ}, 3'b100);
    chk("wr_ram3", ram_mdl[3], 8'hA5);
    exp_d[0] = 8'hA5; exp_m[0] = 4'd3;
    rd_burst(4'd3, 4'd0, 0);

    // 3: response held off for 5 cycles
    rd_burst(4'd3, 4'd0, 5);

    // 2: wrapping 4-beat burst from 14
    ram_put(4'd14, 8'h11); ram_put(4'd15, 8'h22); ram_put(4'd0, 8'h33); ram_put(4'd1, 8'h44);
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    exp_m[0] = 4'd14; exp_m[1] = 4'd15; exp_m[2] = 4'd0; exp_m[3] = 4'd1;
    rd_burst(4'd14, 4'd3, 0);

    // 4: grant dropped during WRITE
    ram_put(4'd5, 8'h00);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd5; cmd_data = 8'h3C; grant = 1;
    @(negedge clk); cmd_valid = 0;
    @(negedge clk); grant = 0;
    #1 chk("wd_nostrobe", {o_RAM_LOAD, o_RAM_OUT, o_BUS_REQ}, 3'b001);
    chk("wd_bus_z", bus, PROBE);
    @(negedge clk); #1 chk("wd_back_req", {o_CMD_READY, o_BUS_REQ, o_BUSY, o_RAM_LOAD}, 4'b0110);
    chk("wd_ram_kept", ram_mdl[5], 8'h00);
    @(negedge clk); #1 chk("wd_wait_req", {o_CMD_READY, o_BUS_REQ, o_BUSY, o_RAM_LOAD}, 4'b0110);
    grant = 1;
    @(negedge clk); #1;
    chk("wd_load", o_RAM_LOAD, 1);
    chk("wd_bus", bus, 8'h3C);
    chk("wd_mar", o_MAR_DATA, 5);
    @(negedge clk); #1;
    chk("wd_ram5", ram_mdl[5], 8'h3C);
    chk("wd_idle", {o_CMD_READY, o_BUSY}, 2'b10);

    // 5: reset during beat 2 of a burst from 0 (RAM[0]=33, RAM[1]=44)
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd0; cmd_len = 4'd3; grant = 1;
    @(negedge clk); cmd_valid = 0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rb_beat1", {o_RSP_VALID, 8'h00, o_RSP_DATA}, {1'b1, 8'h00, 8'h33});
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    @(negedge clk); #1;
    chk("rb_beat2_out", {o_RAM_OUT, 3'b000, o_MAR_DATA}, {1'b1, 3'b000, 4'd1});
    rst_n = 1'b0;
    #1 chk("rb_rst_ctl", {o_CMD_READY, o_BUSY, o_BUS_REQ, o_RSP_VALID, o_RAM_LOAD, o_RAM_OUT}, 6'b0);
    chk("rb_rst_mar", o_MAR_DATA, 0);
    chk("rb_rst_bus", bus, PROBE);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk("rb_no_resume", {o_CMD_READY, o_BUSY, o_BUS_REQ, o_RSP_VALID, o_RAM_OUT}, 5'b10000);
    end
    rsp_ready = 0;

    // Maximum burst: 16 beats from 2, wrapping through 15 -> 0 -> 1
    for (int i = 0; i < 16; i++) ram_put(4'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < 16; i++) begin
      exp_m[i] = 4'(2 + i);
      exp_d[i] = 8'hC0 + 8'(exp_m[i]);
    end
    rd_burst(4'd2, 4'd15, 0);

    // 6: command valid held continuously, grant held: IDLE/REQ/WRITE cycle
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd7; cmd_data = 8'h77; grant = 1;
    for (int k = 0; k < 9; k++) begin
      #1 chk("cv_ready", o_CMD_READY, (k % 3 == 0) ? 1 : 0);
      chk("cv_load", o_RAM_LOAD, (k % 3 == 2) ? 1 : 0);
      @(negedge clk);
    end
    // same with the grant toggling; invariants checked every cycle
    for (int k = 0; k < 12; k++) begin
      grant = k[0];
      @(negedge clk);
    end
    cmd_valid = 0; grant = 1;
    repeat (4) @(negedge clk);
    #1 chk("cv_drained", {o_CMD_READY, o_BUSY}, 2'b10);
    chk("cv_ram7", ram_mdl[7], 8'h77);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
